// File: rtl/core_debug_monitor.sv
// Core debug monitor: watches the retire stream of a core, keeps a PC trace
// FIFO, counts cycles and retired instructions, flags PC breakpoints, and
// detects halt (jump-to-self near the reset vector) and run timeout.
module core_debug_monitor #(
  parameter int               XLEN        = 32,
  parameter int               NUM_BP      = 4,
  parameter int               TRACE_DEPTH = 16,
  parameter int               HB_PERIOD   = 1000000,
  parameter logic [XLEN-1:0]  HALT_LIMIT  = 'h20,
  parameter logic [63:0]      TIMEOUT_CYC = 64'd50000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic                          valid_i,
  input  logic [XLEN-1:0]               pc_i,
  input  logic [31:0]                   instr_i,
  input  logic [NUM_BP-1:0]             bp_en_i,
  input  logic [NUM_BP*XLEN-1:0]        bp_addr_i,
  input  logic                          trace_rd_i,
  output logic [XLEN-1:0]               trace_rdata_o,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count_o,
  output logic                          trace_empty_o,
  output logic                          trace_ovf_o,
  output logic [63:0]                   cycle_cnt_o,
  output logic [63:0]                   instret_o,
  output logic                          heartbeat_o,
  output logic [NUM_BP-1:0]             bp_hit_o,
  output logic                          halt_o,
  output logic                          timeout_o,
  output logic [1:0]                    state_o
);

  localparam int PW   = $clog2(TRACE_DEPTH);
  localparam int CW   = PW + 1;
  localparam int HB_W = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_HALTED  = 2'd2;
  localparam logic [1:0] S_TIMEOUT = 2'd3;

  // "jal x0, 0": the core spinning on itself is how software signals done
  localparam logic [31:0]     HALT_INSTR = 32'h0000006f;
  localparam logic [HB_W-1:0] HB_LAST    = HB_W'(HB_PERIOD - 1);
  localparam logic [63:0]     TO_LAST    = TIMEOUT_CYC - 64'd1;
  localparam logic [CW-1:0]   FULL_CNT   = CW'(TRACE_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [63:0]       cyc_q, cyc_d;
  logic [63:0]       instret_q, instret_d;
  logic [HB_W-1:0]   hb_q, hb_d;
  logic              hb_pulse_q, hb_pulse_d;
  logic [NUM_BP-1:0] bp_hit_q, bp_hit_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [XLEN-1:0]   trace_mem [TRACE_DEPTH];

  logic soft_rst, in_run, halt_evt, push, pop, full;

  assign soft_rst = rst | clear_i;
  assign in_run   = (state_q == S_RUN);
  assign halt_evt = in_run && valid_i && (instr_i == HALT_INSTR) && (pc_i < HALT_LIMIT);
  assign push     = in_run && valid_i;
  // popping an empty FIFO is silently ignored
  assign pop      = trace_rd_i && (count_q != '0);
  assign full     = (count_q == FULL_CNT);

  // Per-channel sticky breakpoint comparators
  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
    logic match;
    assign match       = valid_i && bp_en_i[gi] && (pc_i == bp_addr_i[gi*XLEN +: XLEN]);
    assign bp_hit_d[gi] = bp_hit_q[gi] | (in_run & match);
  end

  // FSM, performance counters and heartbeat next-state
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    instret_d  = instret_q;
    hb_d       = hb_q;
    hb_pulse_d = 1'b0;
    case (state_q)
      S_IDLE: if (enable_i) state_d = S_RUN;
      S_RUN: begin
        // halt wins over timeout when both land in the same cycle
        if (halt_evt)              state_d = S_HALTED;
        else if (cyc_q == TO_LAST) state_d = S_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
    if (in_run) begin
      cyc_d = cyc_q + 64'd1;
      if (valid_i) instret_d = instret_q + 64'd1;
      if (hb_q == HB_LAST) begin
        hb_d       = '0;
        hb_pulse_d = 1'b1;
      end else begin
        hb_d = hb_q + HB_W'(1);
      end
    end
  end

  // Trace FIFO pointer/count next-state; a full push drops the oldest entry
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (push && pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (push && full) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      ovf_d    = 1'b1;
    end else if (push) begin
      count_d = count_q + CW'(1);
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_q - CW'(1);
    end
  end

  // State registers; rst and clear_i override everything else
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      instret_q  <= '0;
      hb_q       <= '0;
      hb_pulse_q <= 1'b0;
      bp_hit_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      instret_q  <= instret_d;
      hb_q       <= hb_d;
      hb_pulse_q <= hb_pulse_d;
      bp_hit_q   <= bp_hit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  // Trace storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) trace_mem[wr_ptr_q] <= pc_i;
  end

  assign trace_rdata_o = (count_q == '0) ? '0 : trace_mem[rd_ptr_q];
  assign trace_count_o = count_q;
  assign trace_empty_o = (count_q == '0);
  assign trace_ovf_o   = ovf_q;
  assign cycle_cnt_o   = cyc_q;
  assign instret_o     = instret_q;
  assign heartbeat_o   = hb_pulse_q;
  assign bp_hit_o      = bp_hit_q;
  assign halt_o        = (state_q == S_HALTED);
  assign timeout_o     = (state_q == S_TIMEOUT);
  assign state_o       = state_q;

endmodule
